signal_trig_gen: RTL

SIGNAL_TRIG_GEN -- requirements
Module: signal_trig_gen

---
 rtl/signal_trig_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/signal_trig_gen.sv
// Trigger burst generator: optional start delay, then num_pulses pulses of a set width and period.
// States: IDLE wait for start | DELAY pre-pulse wait | HIGH pulse active | LOW inter-pulse gap | DONE completion
module signal_trig_gen #(
  parameter int CNT_W = 32,
  parameter int PW_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] period,
  input  logic [PW_W-1:0]  width,
  input  logic [PW_W-1:0]  num_pulses,
  output logic             trig_sig_out,
  output logic             busy,
  output logic             done,
  output logic [PW_W-1:0]  pulse_cnt
);

  typedef enum logic [2:0] {IDLE, DELAY, HIGH, LOW, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] low_q;
  logic [PW_W-1:0]  width_q;
  logic [PW_W-1:0]  num_q;
  logic [PW_W-1:0]  pulse_cnt_q;
  logic             trig_q;
  logic             busy_q;
  logic             done_q;

  logic [PW_W-1:0]  width_d;
  logic [CNT_W-1:0] width_ext_d;
  logic [CNT_W-1:0] low_d;
  logic [CNT_W-1:0] width_q_ext;

  // Low phase length is derived once at start so a short period still leaves one low cycle.
  always_comb begin
    width_d     = (width == '0) ? PW_W'(1) : width;
    width_ext_d = CNT_W'(width_d);
    low_d       = (period > width_ext_d) ? (period - width_ext_d) : CNT_W'(1);
    width_q_ext = CNT_W'(width_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      low_q       <= '0;
      width_q     <= '0;
      num_q       <= '0;
      pulse_cnt_q <= '0;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (stop) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // Outputs follow the state one edge later, so nothing is combinational from inputs.
      trig_q <= (state_q == HIGH);
      busy_q <= (state_q != IDLE);
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            pulse_cnt_q <= '0;
            width_q     <= width_d;
            low_q       <= low_d;
            num_q       <= num_pulses;
            if (delay != '0) begin
              state_q <= DELAY;
              cnt_q   <= delay - CNT_W'(1);
            end else begin
              state_q <= HIGH;
              cnt_q   <= width_ext_d - CNT_W'(1);
            end
          end
        end
        DELAY: begin
          if (cnt_q == '0) begin
            state_q <= HIGH;
            cnt_q   <= width_q_ext - CNT_W'(1);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        HIGH: begin
          if (!trig_q) pulse_cnt_q <= pulse_cnt_q + PW_W'(1);
          if (cnt_q == '0) begin
            state_q <= LOW;
            cnt_q   <= low_q - CNT_W'(1);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        LOW: begin
          if (cnt_q == '0) begin
            if (num_q == '0 || pulse_cnt_q < num_q) begin
              state_q <= HIGH;
              cnt_q   <= width_q_ext - CNT_W'(1);
            end else begin
              state_q <= DONE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trig_sig_out = trig_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pulse_cnt    = pulse_cnt_q;

endmodule
